// File: rtl/irq_stim_seq.sv
// Programmable reset/interrupt stimulus sequencer: reset hold, delay, N irq pulses, tail, optional re-reset.
// Latency: outputs registered, first core_reset cycle follows the start edge; abort/start are levels, no backpressure.
// Optional IRQ_ROTATE_EN: each pulse drives one mask bit, rotating upward with wrap.
module irq_stim_seq #(
    parameter int NUM_IRQ = 2,
    parameter int CNT_W   = 16,
    parameter int PCNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   cfg_rst_cycles,
    input  logic [CNT_W-1:0]   cfg_delay,
    input  logic [CNT_W-1:0]   cfg_width,
    input  logic [CNT_W-1:0]   cfg_gap,
    input  logic [PCNT_W-1:0]  cfg_count,
    input  logic [CNT_W-1:0]   cfg_tail,
    input  logic               cfg_rereset,
    input  logic [NUM_IRQ-1:0] cfg_irq_mask,
    output logic               core_reset,
    output logic [NUM_IRQ-1:0] irq,
    output logic               busy,
    output logic               done,
    output logic [PCNT_W-1:0]  pulse_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_HOLD, S_DELAY, S_PULSE, S_GAP, S_TAIL, S_RERESET, S_FINISH
    } state_t;

    state_t state, state_n;
    state_t tail_entry, pulse_entry, delay_entry;

    logic [CNT_W-1:0]   cnt, cnt_n, cnt_ld;
    logic               ld, launch, pulse_ld;
    logic [CNT_W-1:0]   sh_delay, sh_width, sh_gap, sh_tail;
    logic [PCNT_W-1:0]  sh_count;
    logic               sh_rereset;
    logic [NUM_IRQ-1:0] sh_mask, pulse_vec;

    // Zero-length phases are skipped outright, so each entry resolves the whole chain.
    always_comb begin
        tail_entry  = (sh_tail != '0) ? S_TAIL : (sh_rereset ? S_RERESET : S_FINISH);
        pulse_entry = (sh_count != '0) ? S_PULSE : tail_entry;
        delay_entry = (sh_delay != '0) ? S_DELAY : pulse_entry;
    end

    always_comb begin
        state_n = state;
        ld      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_n = S_RST_HOLD;
                    ld      = 1'b1;
                end
            end
            S_RST_HOLD: if (cnt == '0) begin state_n = delay_entry; ld = 1'b1; end
            S_DELAY:    if (cnt == '0) begin state_n = pulse_entry; ld = 1'b1; end
            S_PULSE: begin
                if (cnt == '0) begin
                    ld = 1'b1;
                    if (pulse_cnt < sh_count)
                        state_n = (sh_gap != '0) ? S_GAP : S_PULSE;
                    else
                        state_n = tail_entry;
                end
            end
            S_GAP:      if (cnt == '0) begin state_n = S_PULSE; ld = 1'b1; end
            S_TAIL: begin
                if (cnt == '0) begin
                    state_n = sh_rereset ? S_RERESET : S_FINISH;
                    ld      = 1'b1;
                end
            end
            S_RERESET:  begin state_n = S_FINISH; ld = 1'b1; end
            S_FINISH:   state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_n = S_IDLE;
            ld      = 1'b0;
        end
    end

    assign launch   = (state == S_IDLE) && (state_n == S_RST_HOLD);
    assign pulse_ld = ld && (state_n == S_PULSE);

    // Counters hold "cycles remaining minus one"; the reset hold reads cfg directly at launch.
    always_comb begin
        cnt_ld = '0;
        case (state_n)
            S_RST_HOLD: cnt_ld = (cfg_rst_cycles == '0) ? '0 : cfg_rst_cycles - CNT_W'(1);
            S_DELAY:    cnt_ld = sh_delay - CNT_W'(1);
            S_PULSE:    cnt_ld = (sh_width == '0) ? '0 : sh_width - CNT_W'(1);
            S_GAP:      cnt_ld = sh_gap - CNT_W'(1);
            S_TAIL:     cnt_ld = sh_tail - CNT_W'(1);
            default:    cnt_ld = '0;
        endcase
        if (state_n == S_IDLE)
            cnt_n = '0;
        else if (ld)
            cnt_n = cnt_ld;
        else if (cnt != '0)
            cnt_n = cnt - CNT_W'(1);
        else
            cnt_n = cnt;
    end

`ifdef IRQ_ROTATE_EN
    localparam int PTR_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [PTR_W-1:0]   rot_ptr, rot_nxt;
    logic [NUM_IRQ-1:0] rot_vec;
    logic               rot_hit;
    int                 rot_idx;

    always_comb begin
        rot_vec = '0;
        rot_nxt = rot_ptr;
        rot_hit = 1'b0;
        rot_idx = 0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            rot_idx = (int'(rot_ptr) + i) % NUM_IRQ;
            if (!rot_hit && sh_mask[rot_idx]) begin
                rot_hit          = 1'b1;
                rot_vec[rot_idx] = 1'b1;
                rot_nxt          = (rot_idx == NUM_IRQ - 1) ? '0 : PTR_W'(rot_idx + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rot_ptr <= '0;
        else if (launch)
            rot_ptr <= '0;
        else if (pulse_ld && rot_hit)
            rot_ptr <= rot_nxt;
    end

    assign pulse_vec = rot_vec;
`else
    assign pulse_vec = sh_mask;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sh_delay   <= '0;
            sh_width   <= '0;
            sh_gap     <= '0;
            sh_tail    <= '0;
            sh_count   <= '0;
            sh_rereset <= 1'b0;
            sh_mask    <= '0;
            pulse_cnt  <= '0;
            core_reset <= 1'b0;
            irq        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (launch) begin
                sh_delay   <= cfg_delay;
                sh_width   <= cfg_width;
                sh_gap     <= cfg_gap;
                sh_tail    <= cfg_tail;
                sh_count   <= cfg_count;
                sh_rereset <= cfg_rereset;
                sh_mask    <= cfg_irq_mask;
                pulse_cnt  <= '0;
            end else if (pulse_ld) begin
                pulse_cnt  <= pulse_cnt + PCNT_W'(1);
            end
            // Outputs are decoded from the next state so they line up with the state they describe.
            core_reset <= (state_n == S_RST_HOLD) || (state_n == S_RERESET);
            busy       <= (state_n != S_IDLE) && (state_n != S_FINISH);
            done       <= (state_n == S_FINISH);
            if (state_n != S_PULSE)
                irq <= '0;
            else if (ld)
                irq <= pulse_vec;
        end
    end

endmodule

// File: tb/tb_irq_stim_seq.sv
// Directed bench for irq_stim_seq: a per-cycle timeline model built from the schedule rules, checked every cycle.
module tb_irq_stim_seq;
    localparam int N  = 4;
    localparam int CW = 16;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] cfg_rst_cycles = '0, cfg_delay = '0, cfg_width = '0, cfg_gap = '0, cfg_tail = '0;
    logic [PW-1:0] cfg_count = '0;
    logic          cfg_rereset = 1'b0;
    logic [N-1:0]  cfg_irq_mask = '0;
    logic          core_reset, busy, done;
    logic [N-1:0]  irq;
    logic [PW-1:0] pulse_cnt;

    always #5 clk = ~clk;

    irq_stim_seq #(.NUM_IRQ(N), .CNT_W(CW), .PCNT_W(PW)) dut (
        .clk(clk), .reset(rst_n), .start(start), .abort(abort),
        .cfg_rst_cycles(cfg_rst_cycles), .cfg_delay(cfg_delay), .cfg_width(cfg_width),
        .cfg_gap(cfg_gap), .cfg_count(cfg_count), .cfg_tail(cfg_tail),
        .cfg_rereset(cfg_rereset), .cfg_irq_mask(cfg_irq_mask),
        .core_reset(core_reset), .irq(irq), .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
    );

    typedef struct packed {
        logic          cr;
        logic [N-1:0]  irq;
        logic          busy;
        logic          done;
        logic [PW-1:0] pc;
    } exp_t;

    exp_t         sched[$];
    exp_t         exp_q[$];
    logic [N-1:0] pv[$];
    exp_t         chk_e;
    string        tname = "reset";
    int           vectors = 0;
    int           errs = 0;
    int           cyc = 0;

    function automatic exp_t mk(input logic cr, input logic [N-1:0] v, input logic b,
                                input logic d, input logic [PW-1:0] pc);
        exp_t e;
        e.cr = cr; e.irq = v; e.busy = b; e.done = d; e.pc = pc;
        return e;
    endfunction

    // Expected output of every cycle after the start edge, plus one idle cycle.
    task automatic build(input int rst_c, input int dly, input int wid, input int gp,
                         input int cnt, input int tl, input bit rr, input logic [N-1:0] msk);
        int ptr;
        logic [N-1:0] v;
        ptr = 0;
        sched.delete();
        pv.delete();
        repeat ((rst_c == 0) ? 1 : rst_c) sched.push_back(mk(1'b1, '0, 1'b1, 1'b0, '0));
        repeat (dly) sched.push_back(mk(1'b0, '0, 1'b1, 1'b0, '0));
        for (int p = 1; p <= cnt; p++) begin
`ifdef IRQ_ROTATE_EN
            v = '0;
            for (int k = 0; k < N; k++) begin
                if (v == '0 && msk[(ptr + k) % N]) begin
                    v[(ptr + k) % N] = 1'b1;
                    ptr = (ptr + k + 1) % N;
                end
            end
`else
            v = msk;
`endif
            pv.push_back(v);
            repeat ((wid == 0) ? 1 : wid) sched.push_back(mk(1'b0, v, 1'b1, 1'b0, PW'(p)));
            if (p < cnt) repeat (gp) sched.push_back(mk(1'b0, '0, 1'b1, 1'b0, PW'(p)));
        end
        repeat (tl) sched.push_back(mk(1'b0, '0, 1'b1, 1'b0, PW'(cnt)));
        if (rr) sched.push_back(mk(1'b1, '0, 1'b1, 1'b0, PW'(cnt)));
        sched.push_back(mk(1'b0, '0, 1'b0, 1'b1, PW'(cnt)));
        sched.push_back(mk(1'b0, '0, 1'b0, 1'b0, PW'(cnt)));
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() != 0) begin
            chk_e = exp_q.pop_front();
            vectors++;
            if ({core_reset, irq, busy, done, pulse_cnt} !== chk_e) begin
                errs++;
                $display("FAIL %s t=%0t: got cr=%b irq=%b busy=%b done=%b pc=%0d, expected cr=%b irq=%b busy=%b done=%b pc=%0d",
                         tname, $time, core_reset, irq, busy, done, pulse_cnt,
                         chk_e.cr, chk_e.irq, chk_e.busy, chk_e.done, chk_e.pc);
            end
        end
    end

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 5000) begin
            @(posedge clk);
            g++;
        end
        check({tname, " drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic launch(input int rst_c, input int dly, input int wid, input int gp,
                          input int cnt, input int tl, input bit rr, input logic [N-1:0] msk);
        cfg_rst_cycles = CW'(rst_c); cfg_delay = CW'(dly); cfg_width = CW'(wid);
        cfg_gap = CW'(gp); cfg_count = PW'(cnt); cfg_tail = CW'(tl);
        cfg_rereset = rr; cfg_irq_mask = msk;
        build(rst_c, dly, wid, gp, cnt, tl, rr, msk);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run(input string nm, input int rst_c, input int dly, input int wid, input int gp,
                       input int cnt, input int tl, input bit rr, input logic [N-1:0] msk,
                       input int abort_at);
        tname = nm;
        launch(rst_c, dly, wid, gp, cnt, tl, rr, msk);
        // Scrambled cfg after launch must not disturb the running schedule.
        cfg_rst_cycles = 7; cfg_delay = 7; cfg_width = 7; cfg_gap = 7;
        cfg_count = 7; cfg_tail = 7; cfg_rereset = 1'b0; cfg_irq_mask = '1;
        if (abort_at > 0) begin
            for (int i = 0; i < abort_at; i++) exp_q.push_back(sched[i]);
            repeat (3) exp_q.push_back(mk(1'b0, '0, 1'b0, 1'b0, sched[abort_at-1].pc));
            repeat (abort_at - 1) begin @(posedge clk); #1; end
            abort = 1'b1;
            @(posedge clk); #1 abort = 1'b0;
        end else begin
            exp_q = sched;
        end
        drain();
    endtask

    initial begin
        int hi, first, didx;
        #12;
        check("rst core_reset", core_reset, 0);
        check("rst irq", irq, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst pulse_cnt", pulse_cnt, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        run("baseline", 1, 15, 1, 0, 1, 40, 1'b1, 4'b0001, 0);
        first = -1;
        foreach (sched[i]) if (first < 0 && sched[i].irq != '0) first = i;
        check("baseline model length", sched.size(), 60);
        check("baseline model first irq", first, 16);
        check("baseline model rereset", sched[57].cr, 1);
        check("baseline pulse_cnt", pulse_cnt, 1);

        run("multi", 2, 3, 3, 2, 4, 2, 1'b0, 4'b0011, 0);
        hi = 0;
        foreach (sched[i]) if (sched[i].irq != '0) hi++;
        check("multi model irq cycles", hi, 12);
        check("multi pulse_cnt", pulse_cnt, 4);

        run("zero_edges", 0, 0, 0, 0, 3, 0, 1'b0, 4'b0011, 0);
        check("zero model length", sched.size(), 6);
        check("zero pulse_cnt", pulse_cnt, 3);

        run("count0", 2, 3, 2, 1, 0, 5, 1'b0, 4'b0011, 0);
        didx = -1;
        foreach (sched[i]) if (didx < 0 && sched[i].done) didx = i;
        check("count0 model done index", didx, 10);
        check("count0 pulse_cnt", pulse_cnt, 0);

        run("rotate", 1, 1, 2, 1, 3, 1, 1'b0, 4'b1010, 0);
`ifdef IRQ_ROTATE_EN
        check("rotate model p1", pv[0], 4'b0010);
        check("rotate model p2", pv[1], 4'b1000);
        check("rotate model p3", pv[2], 4'b0010);
`else
        check("rotate model p1", pv[0], 4'b1010);
        check("rotate model p2", pv[1], 4'b1010);
        check("rotate model p3", pv[2], 4'b1010);
`endif

        run("mask0", 1, 0, 2, 1, 2, 1, 1'b1, 4'b0000, 0);
        check("mask0 pulse_cnt", pulse_cnt, 2);

        run("abort", 1, 0, 3, 2, 4, 3, 1'b1, 4'b0011, 8);
        check("abort pulse_cnt", pulse_cnt, 2);

        tname = "abort_start";
        cfg_count = 1;
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        repeat (3) exp_q.push_back(mk(1'b0, '0, 1'b0, 1'b0, 8'd2));
        drain();

        tname = "async_gap";
        launch(1, 0, 3, 5, 2, 1, 1'b1, 4'b0011);
        for (int i = 0; i < 5; i++) exp_q.push_back(sched[i]);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("async core_reset", core_reset, 0);
        check("async irq", irq, 0);
        check("async busy", busy, 0);
        check("async done", done, 0);
        check("async pulse_cnt", pulse_cnt, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) exp_q.push_back(mk(1'b0, '0, 1'b0, 1'b0, '0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/irq_stim_seq.md
Name: irq_stim_seq

Overview:
- Synthesizable, parametrised reset/interrupt stimulus sequencer for the RISCV pipelined core with CSRs.
- Replaces hand-coded reset and interrupt waveforms with a programmable schedule: reset hold, delay, N interrupt pulses of set width and gap, tail, optional re-reset.
- Drives the core's active-high `reset` and `interrupt[NUM_IRQ-1:0]` inputs.
- Used in simulation benches and in FPGA self-test wrappers.

Parameters:
- NUM_IRQ, 2, width of the interrupt vector driven to the core.
- CNT_W, 16, width of all cycle-count config fields and internal counters.
- PCNT_W, 8, width of pulse-count config and pulse counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset of this block.
- start  in  1  level. Sampled only in IDLE; launches the schedule.
- abort  in  1  level. Highest priority; returns to IDLE.
- cfg_rst_cycles  in  CNT_W  core reset hold length.
- cfg_delay  in  CNT_W  cycles from reset release to first pulse.
- cfg_width  in  CNT_W  pulse width.
- cfg_gap  in  CNT_W  cycles between pulses.
- cfg_count  in  PCNT_W  number of pulses.
- cfg_tail  in  CNT_W  cycles after last pulse before finish.
- cfg_rereset  in  1  assert core reset for one cycle at end.
- cfg_irq_mask  in  NUM_IRQ  interrupt lines used by pulses.
- core_reset  out  1  active-high reset to the core.
- irq  out  NUM_IRQ  interrupt vector to the core.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on normal completion.
- pulse_cnt  out  PCNT_W  pulses issued in the current run.

Behaviour:
- Async reset (reset=0) values:
  - state=IDLE; core_reset=0; irq=0; busy=0; done=0; pulse_cnt=0; counters=0.
  - Rotation pointer=0 (feature on).
- All outputs are registered.
- On the edge where state=IDLE and start=1:
  - latch all cfg_* into shadow registers, clear pulse_cnt, enter RST_HOLD.
  - cfg_* changes after this edge have no effect until the next start.
- States and transitions:
  - IDLE: all outputs 0 except pulse_cnt, which holds its last value.
  - RST_HOLD: core_reset=1 for max(cfg_rst_cycles,1) cycles, then DELAY.
  - DELAY: irq=0 for cfg_delay cycles. If cfg_delay=0, go straight to PULSE, so PULSE starts in the cycle after the last RST_HOLD cycle.
  - PULSE: irq=vector for max(cfg_width,1) cycles.
    - pulse_cnt increments on the first PULSE cycle.
    - On exit: go to GAP if pulse_cnt<cfg_count, else TAIL.
  - GAP: irq=0 for cfg_gap cycles, then PULSE. With cfg_gap=0, pulses are back-to-back and irq stays high across the boundary.
  - TAIL: irq=0 for cfg_tail cycles. Then RERESET if cfg_rereset=1, else FINISH.
  - RERESET: core_reset=1 for exactly 1 cycle, then FINISH.
  - FINISH: done=1 for 1 cycle, busy=0, then IDLE.
- cfg_count=0: skip PULSE/GAP; DELAY goes directly to TAIL; pulse_cnt stays 0.
- cfg_irq_mask=0: PULSE timing unchanged, irq stays 0, pulse_cnt still counts.
- Counters are CNT_W wide, down-count, no wrap. A value of all-ones gives 2^CNT_W-1 cycles.
- Abort:
  - abort=1 in any non-IDLE state → IDLE on the next edge.
  - core_reset and irq drop to 0 that same edge; done is not asserted.
  - pulse_cnt holds its value.
  - abort and start together in IDLE: abort wins, no launch.
- Async reset mid-run: immediate return to reset values; no done.

Optional Feature:
- Macro: IRQ_ROTATE_EN.
- Defined: each pulse asserts a single line, the next set bit of cfg_irq_mask at or after a rotation pointer, searching upward with wrap.
  - The pointer advances past the used bit after each pulse.
  - The pointer resets to 0 at each start.
  - mask=0 gives irq=0.
- Undefined: every pulse asserts irq=cfg_irq_mask; no pointer logic is synthesised.

Test Plan:
- Baseline core schedule: rst=1, delay=15, width=1, count=1, tail=40, rereset=1, mask=2'b01.
  - core_reset high 1 cycle after start.
  - irq=01 for exactly 1 cycle, starting 16 cycles after reset release.
  - core_reset high 1 cycle 41 cycles after the pulse.
  - done pulses once; pulse_cnt=1.
- Multi-pulse: width=3, gap=2, count=4, mask=2'b11.
  - irq=11 in four 3-cycle bursts separated by 2 low cycles.
  - pulse_cnt=4 at done.
- Zero edges: rst=0, delay=0, width=0, gap=0, count=3.
  - core_reset 1 cycle, then irq continuously high for 3 cycles; pulse_cnt=3.
- count=0, tail=5, rereset=0: no irq ever; done exactly 5 cycles after DELAY ends.
- Abort during the 2nd PULSE: irq and core_reset are 0 the next cycle; state IDLE; no done; pulse_cnt=2.
  - Async reset asserted during GAP: all outputs are 0 immediately.
- IRQ_ROTATE_EN with NUM_IRQ=4, mask=4'b1010, count=3: successive pulses are 0010, 1000, 0010.
  - Without the macro: all pulses are 1010.
